// File: rtl/dmem_responder_pkg.sv
// Shared CPU data-memory definitions: responder FSM states and default geometry/timing.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DEPTH_DEFAULT   = 256;
    localparam int unsigned DMEM_LATENCY_DEFAULT = 2;
    localparam int unsigned DMEM_CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: fixed-latency access FSM that stalls the pipeline
// and reports alignment, range and request-conflict errors.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]         word_q, word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  isStore_q, isStore_d;
    logic                  isErr_q, isErr_d;

    logic        req;
    logic        reqErr;
    logic        memWe;
    logic [31:0] memRdata;

    assign req    = MemRead | MemWrite;
    assign reqErr = (addr[1:0] != 2'b00) | (|addr[31:AW+2]) | (MemRead & MemWrite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            isStore_q <= 1'b0;
            isErr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            isStore_q <= isStore_d;
            isErr_q   <= isErr_d;
        end
    end

    // The write strobe is qualified by rst_n so a reset landing on the WAIT->RESP edge never commits.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        isStore_d = isStore_q;
        isErr_d   = isErr_q;
        stall     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rdata     = '0;
        memWe     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && rst_n) begin
                    stall     = 1'b1;
                    word_d    = addr[AW+1:2];
                    wdata_d   = wdata;
                    isStore_d = MemWrite;
                    isErr_d   = reqErr;
                    count_d   = DMEM_CNT_W'(LATENCY - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (count_q == '0) begin
                    memWe   = isStore_q & ~isErr_q & rst_n;
                    state_d = RESP;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            RESP: begin
                done    = 1'b1;
                err     = isErr_q;
                state_d = IDLE;
                if (!isStore_q && !isErr_q) begin
                    rdata = memRdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) uArray (
        .clk_i  (clk),
        .we_i   (memWe),
        .addr_i (word_q),
        .wdata_i(wdata_q),
        .rdata_o(memRdata)
    );

endmodule
